instr_loader: RTL
=================

# instr_loader

Boot-time program loader that sits in front of the RV32I core's instruction memory and is the writer counterpart to the core's fetch path. The core only reads `instr_mem`; this block receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit instructions. It writes them into the instruction memory through a dedicated write port, verifies a checksum, and holds the core in reset until a load has completed cleanly.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: byte address width of instruction memory; matches the core's `PC[7:0]` fetch.
- `INSTR_LEN`, default 32: instruction width in bits.
- `MAX_WORDS`, default 64: maximum words per frame. `MAX_WORDS*4 <= 2**ADDR_WIDTH` is required.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `byte_valid`, input, 1: source has a byte.
- `byte_data`, input, 8: stream byte.
- `byte_ready`, output, 1: loader accepts a byte this cycle.
- `wr_en`, output, 1: instruction memory write strobe, one cycle per word.
- `wr_addr`, output, ADDR_WIDTH: byte address, word aligned.
- `wr_data`, output, INSTR_LEN: instruction word.
- `cpu_rst`, output, 1: active-high reset to the core's `rst`.
- `done`, output, 1: last frame loaded and checksum matched.
- `err`, output, 1: last frame rejected.
- `word_count`, output, 7: words written in the current or last frame.

## Operation
- Frame layout: sync `0xA5`, then length byte N (number of words), then 4N data bytes (least significant byte first per word), then a checksum byte. The checksum is the XOR of all 4N data bytes.
- A transfer occurs on a rising edge where `byte_valid && byte_ready`. `byte_ready = !wr_en` in every state.
- FSM states:
  - IDLE: accepted bytes other than `0xA5` are discarded. `0xA5` moves to LEN.
  - LEN: N=0 or N>MAX_WORDS moves to ERROR. Otherwise latch N, clear `word_count` and the checksum, and move to DATA.
  - DATA: shift each byte into bits [8k+7:8k] for k=0..3 and XOR it into the checksum. On the 4th byte, the next cycle issues `wr_en=1` with `wr_addr=word_count*4` and the assembled `wr_data`, then `word_count` increments. After word N is accepted, move to CHECK.
  - CHECK: a byte equal to the running checksum moves to DONE; any other value moves to ERROR.
  - DONE: `cpu_rst=0`, `done=1`. An accepted `0xA5` asserts `cpu_rst`, clears `done`, and moves to LEN (reload). Other bytes are ignored.
  - ERROR: `cpu_rst=1`, `err=1`. An accepted `0xA5` clears `err` and moves to LEN. Other bytes are ignored.
- `cpu_rst` is 1 in every state except DONE.
- Memory words already written by a failed frame remain in memory. The core stays in reset, so they are never executed.

## Timing
- Reset values: state IDLE, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `cpu_rst=1`, `done=0`, `err=0`, `word_count=0`, and the byte index and checksum are 0. No transfer is accepted while `rst` is low.
- All outputs except `byte_ready` are registered.
- Write latency: `wr_en` is high in the cycle after the 4th byte of a word is accepted, for exactly one cycle. `byte_ready` is low in that cycle, which gives one bubble per word.
- Max throughput: 4 bytes per 5 cycles in DATA, otherwise 1 byte per cycle.
- `done`/`cpu_rst` change in the cycle after the checksum byte is accepted. `err` is set in the cycle after the offending LEN or CHECK byte.
- A sync byte arriving while in DATA is treated as data, not a resync.
- Asynchronous reset mid-frame aborts the frame immediately: the FSM returns to IDLE and `cpu_rst=1`. A `wr_en` pulse in flight is dropped.

## Structure
- `loader_pkg`: state enum (IDLE, LEN, DATA, CHECK, DONE, ERROR), `SYNC_BYTE = 8'hA5`, and the byte-index width.
- Sub-module `word_assembler`: 2-bit byte index, 32-bit shift register, `word_valid` pulse, and clear input.
- The top contains the FSM, checksum, counters, and write-port registers.

## Test plan
- Reset, then frame A5 01 13 05 A0 00 B6: `wr_en` pulses once with `wr_addr=0x00` and `wr_data=0x00A00513`. Next cycle `done=1`, `cpu_rst=0`, `word_count=1`.
- Frame with N=3 and back-to-back valid bytes: three `wr_en` pulses at addresses 0x00, 0x04, 0x08; `byte_ready` is low exactly in each write cycle; `done=1`.
- Same as case 1 but checksum 0xB7: `err=1`, `cpu_rst` stays 1, `done=0`. A following valid frame clears `err` and sets `done`.
- Length bytes 0x00 and 0x41 (MAX_WORDS=64): immediate ERROR and no `wr_en`. Junk bytes 0x00 and 0xFF before sync in IDLE are ignored.
- In DONE, send a new frame: `cpu_rst` rises the cycle after `0xA5` is accepted and `done` clears; after the new load, `cpu_rst=0` again.
- Assert `rst` after 2 data bytes of word 1: all outputs return to reset values at once. A full frame sent after reset loads correctly starting at address 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         BIDX_W    = 2;

endpackage

// File: rtl/word_assembler.sv
// Packs four little-endian stream bytes into one 32-bit instruction word.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        word_valid,
   output logic [31:0] word_next
);

   logic [BIDX_W-1:0] idx_q, idx_d;
   logic [31:0]       shift_q, shift_d;

   always_comb begin
      word_next                = shift_q;
      word_next[8*idx_q +: 8]  = in_data;
      // Combinational so the write port can register the word on the same edge
      // that accepts the 4th byte.
      word_valid = in_valid && !clr && (idx_q == BIDX_W'(3));
      idx_d      = idx_q;
      shift_d    = shift_q;
      if (clr) begin
         idx_d   = '0;
         shift_d = '0;
      end else if (in_valid) begin
         idx_d   = idx_q + BIDX_W'(1);
         shift_d = word_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/instr_loader.sv
// Framed byte-stream loader: writes instruction memory, checks an XOR checksum,
// and releases the core from reset only after a clean load.
//
// state | meaning
// IDLE  | waiting for sync byte, everything else discarded
// LEN   | next byte is the word count N
// DATA  | collecting 4N data bytes, one memory write per word
// CHECK | next byte is compared against the running checksum
// DONE  | load good, core released; sync byte starts a reload
// ERROR | frame rejected, core held; sync byte starts a reload
module instr_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int INSTR_LEN  = 32,
   parameter int MAX_WORDS  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [INSTR_LEN-1:0]  wr_data,
   output logic                  cpu_rst,
   output logic                  done,
   output logic                  err,
   output logic [6:0]            word_count
);

   state_t                state_q, state_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [INSTR_LEN-1:0]  wr_data_q, wr_data_d;
   logic                  cpu_rst_q, cpu_rst_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [6:0]            word_count_q, word_count_d;
   logic [6:0]            len_q, len_d;
   logic [7:0]            csum_q, csum_d;

   logic                  accept;
   logic                  asm_clr;
   logic                  asm_valid;
   logic                  word_valid;
   logic [31:0]           word_next;

   assign byte_ready = !wr_en_q;
   assign accept     = byte_valid && byte_ready;
   assign asm_valid  = accept && (state_q == ST_DATA);

   word_assembler u_asm (
      .clk        (clk),
      .rst_n      (rst),
      .clr        (asm_clr),
      .in_valid   (asm_valid),
      .in_data    (byte_data),
      .word_valid (word_valid),
      .word_next  (word_next)
   );

   always_comb begin
      state_d      = state_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      cpu_rst_d    = cpu_rst_q;
      done_d       = done_q;
      err_d        = err_q;
      word_count_d = word_count_q;
      len_d        = len_q;
      csum_d       = csum_q;
      asm_clr      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (accept && byte_data == SYNC_BYTE) state_d = ST_LEN;
         end
         ST_LEN: begin
            if (accept) begin
               if (byte_data == 8'd0 || 32'(byte_data) > MAX_WORDS) begin
                  state_d   = ST_ERROR;
                  err_d     = 1'b1;
                  cpu_rst_d = 1'b1;
               end else begin
                  state_d      = ST_DATA;
                  len_d        = 7'(byte_data);
                  word_count_d = '0;
                  csum_d       = '0;
                  asm_clr      = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
               csum_d = csum_q ^ byte_data;
               if (word_valid) begin
                  wr_en_d      = 1'b1;
                  wr_addr_d    = ADDR_WIDTH'({word_count_q, 2'b00});
                  wr_data_d    = INSTR_LEN'(word_next);
                  word_count_d = word_count_q + 7'd1;
                  if (word_count_q + 7'd1 == len_q) state_d = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            if (accept) begin
               if (byte_data == csum_q) begin
                  state_d   = ST_DONE;
                  done_d    = 1'b1;
                  cpu_rst_d = 1'b0;
               end else begin
                  state_d   = ST_ERROR;
                  err_d     = 1'b1;
                  cpu_rst_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (accept && byte_data == SYNC_BYTE) begin
               state_d   = ST_LEN;
               cpu_rst_d = 1'b1;
               done_d    = 1'b0;
            end
         end
         ST_ERROR: begin
            if (accept && byte_data == SYNC_BYTE) begin
               state_d = ST_LEN;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            cpu_rst_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         cpu_rst_q    <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         word_count_q <= '0;
         len_q        <= '0;
         csum_q       <= '0;
      end else begin
         state_q      <= state_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         cpu_rst_q    <= cpu_rst_d;
         done_q       <= done_d;
         err_q        <= err_d;
         word_count_q <= word_count_d;
         len_q        <= len_d;
         csum_q       <= csum_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign cpu_rst    = cpu_rst_q;
   assign done       = done_q;
   assign err        = err_q;
   assign word_count = word_count_q;

endmodule
